// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: error cause
// encodings, byte-lane geometry and the masked lane merge.
package dmem_pkg;

  localparam int unsigned LANE_W  = 8;
  localparam int unsigned N_LANES = 4;
  localparam int unsigned WORD_W  = LANE_W * N_LANES;
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RW_BOTH  = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_RANGE    = 2'd3
  } err_cause_t;

  // Lanes with mask set take wdata, all others keep the old word's bytes.
  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0]  old_word,
    input logic [WORD_W-1:0]  wdata,
    input logic [N_LANES-1:0] mask
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int n = 0; n < int'(N_LANES); n++) begin
      if (mask[n]) begin
        res[n*LANE_W +: LANE_W] = wdata[n*LANE_W +: LANE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of backing store: DEPTH_WORDS x 8 bits, single write port
// and combinational read at the same index. Contents are never reset.
module dmem_byte_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [LANE_W-1:0] i_wdata,
  output logic [LANE_W-1:0] o_rdata
);

  logic [LANE_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the hart data port: decode, per-lane banks,
// sticky first-violation capture and saturating access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  input  logic        i_err_clr,
  output logic        o_err,
  output logic [1:0]  o_err_cause,
  output logic [31:0] o_err_addr,
  output logic [31:0] o_rd_count,
  output logic [31:0] o_wr_count
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  logic [32:0]       w_off;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_active;
  err_cause_t        w_cause;
  logic              w_viol;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_merged;
  logic [WORD_W-1:0] w_rdata;

  logic              r_err;
  err_cause_t        r_err_cause;
  logic [31:0]       r_err_addr;
  logic [31:0]       r_rd_count;
  logic [31:0]       r_wr_count;

  // 33-bit offset: an address below BASE_ADDR wraps past SPAN_BYTES, so one
  // compare covers both bounds without overflow near the top of the space.
  assign w_off      = {1'b0, i_dmem_addr} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_off < SPAN_BYTES);
  assign w_idx      = IDX_W'(w_off >> 2);
  assign w_active   = i_dmem_ren | i_dmem_wen;

  always_comb begin
    w_cause = ERR_NONE;
    if (w_active) begin
      if (i_dmem_ren && i_dmem_wen) begin
        w_cause = ERR_RW_BOTH;
      end else if (i_dmem_addr[1:0] != 2'b00) begin
        w_cause = ERR_MISALIGN;
      end else if (!w_in_range) begin
        w_cause = ERR_RANGE;
      end
    end
  end

  assign w_viol  = (w_cause != ERR_NONE);
  assign w_rd_ok = i_dmem_ren & ~i_dmem_wen & ~w_viol & ~i_rst;
  assign w_wr_ok = i_dmem_wen & ~i_dmem_ren & ~w_viol & ~i_rst;

  // Each bank rewrites its byte every legal write; unmasked lanes rewrite
  // their own old value, which keeps one shared write enable.
  assign w_merged = lane_merge(w_word, i_dmem_wdata, i_dmem_mask);

  for (genvar n = 0; n < int'(N_LANES); n++) begin : g_lane
    dmem_byte_bank #(
      .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (w_wr_ok),
      .i_addr  (w_idx),
      .i_wdata (w_merged[n*LANE_W +: LANE_W]),
      .o_rdata (w_word[n*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd_ok) begin
      for (int n = 0; n < int'(N_LANES); n++) begin
        if (i_dmem_mask[n]) begin
          w_rdata[n*LANE_W +: LANE_W] = w_word[n*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign o_dmem_rdata = w_rdata;

  // First violation wins until cleared; a violation alongside clear re-arms.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err       <= 1'b0;
      r_err_cause <= ERR_NONE;
      r_err_addr  <= '0;
    end else if (w_viol && (!r_err || i_err_clr)) begin
      r_err       <= 1'b1;
      r_err_cause <= w_cause;
      r_err_addr  <= i_dmem_addr;
    end else if (i_err_clr) begin
      r_err       <= 1'b0;
      r_err_cause <= ERR_NONE;
      r_err_addr  <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_ok && (r_rd_count != CNT_MAX)) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr_ok && (r_wr_count != CNT_MAX)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign o_err       = r_err;
  assign o_err_cause = r_err_cause;
  assign o_err_addr  = r_err_addr;
  assign o_rd_count  = r_rd_count;
  assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed vectors checked with
// immediate assertions; inputs change on the falling edge.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic        err_clr;
  logic        err;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_dmem_addr  (addr),
    .i_dmem_ren   (ren),
    .i_dmem_wen   (wen),
    .i_dmem_wdata (wdata),
    .i_dmem_mask  (mask),
    .o_dmem_rdata (rdata),
    .i_err_clr    (err_clr),
    .o_err        (err),
    .o_err_cause  (err_cause),
    .o_err_addr   (err_addr),
    .o_rd_count   (rd_count),
    .o_wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m, input logic c);
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d; mask = m; err_clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string tag, input logic e, input logic [1:0] c,
                         input logic [31:0] a);
    chk({tag, "_err"},   32'(err),       32'(e));
    chk({tag, "_cause"}, 32'(err_cause), 32'(c));
    chk({tag, "_addr"},  err_addr,       a);
  endtask

  initial begin
    rst = 1'b1; ren = 1'b1; wen = 1'b0; addr = 32'h0; wdata = 32'h0;
    mask = 4'hF; err_clr = 1'b0;
    #12;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rdcnt", rd_count, 32'h0);
    chk("rst_wrcnt", wr_count, 32'h0);
    chk_err("rst", 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0; ren = 1'b0;

    // Full-word write then read
    step(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0); tick();
    chk("wr1_cnt", wr_count, 32'd1);
    step(1, 0, 32'h10, 32'h0, 4'hF, 0);
    chk("rd1_data", rdata, 32'hDEADBEEF);
    tick();
    chk("rd1_cnt", rd_count, 32'd1);

    // Single-byte write, then full and partial-mask reads
    step(0, 1, 32'h10, 32'h55000000, 4'b1000, 0); tick();
    chk("wr2_cnt", wr_count, 32'd2);
    step(1, 0, 32'h10, 32'h0, 4'hF, 0);
    chk("rd2_data", rdata, 32'h55ADBEEF);
    tick();
    step(1, 0, 32'h10, 32'h0, 4'b1100, 0);
    chk("rd3_data", rdata, 32'h55AD0000);
    tick();
    chk("rd3_cnt", rd_count, 32'd3);

    // ren&wen together: captured, array untouched, counters hold
    step(0, 1, 32'h20, 32'h12345678, 4'hF, 0); tick();
    step(1, 1, 32'h20, 32'h00000001, 4'hF, 0);
    chk("rw_rdata", rdata, 32'h0);
    tick();
    chk_err("rw", 1'b1, 2'd1, 32'h20);
    chk("rw_wrcnt", wr_count, 32'd3);
    chk("rw_rdcnt", rd_count, 32'd3);
    step(1, 0, 32'h20, 32'h0, 4'hF, 0);
    chk("rw_mem", rdata, 32'h12345678);
    tick();

    // Later misaligned read does not overwrite
    step(1, 0, 32'h23, 32'h0, 4'hF, 0);
    chk("mis_rdata", rdata, 32'h0);
    tick();
    chk_err("mis_sticky", 1'b1, 2'd1, 32'h20);
    chk("mis_rdcnt", rd_count, 32'd4);

    step(0, 0, 32'h0, 32'h0, 4'h0, 1); tick();
    chk_err("clr1", 1'b0, 2'd0, 32'h0);

    // Range boundary: 0x1000 out, 0xFFC in
    step(1, 0, 32'h1000, 32'h0, 4'hF, 0);
    chk("oor_rdata", rdata, 32'h0);
    tick();
    chk_err("oor", 1'b1, 2'd3, 32'h1000);
    chk("oor_rdcnt", rd_count, 32'd4);
    step(0, 1, 32'hFFC, 32'hCAFEF00D, 4'hF, 0); tick();
    chk("top_wrcnt", wr_count, 32'd4);
    step(1, 0, 32'hFFC, 32'h0, 4'hF, 0);
    chk("top_rdata", rdata, 32'hCAFEF00D);
    tick();
    step(1, 0, 32'hFFFFFFFC, 32'h0, 4'hF, 0);
    chk("hi_rdata", rdata, 32'h0);
    tick();
    chk_err("hi_sticky", 1'b1, 2'd3, 32'h1000);

    // Zero-mask accesses: counted, no data, no change
    step(1, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("m0r_rdata", rdata, 32'h0);
    tick();
    chk("m0r_cnt", rd_count, 32'd6);
    step(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 0); tick();
    chk("m0w_cnt", wr_count, 32'd5);
    step(1, 0, 32'h10, 32'h0, 4'hF, 0);
    chk("m0w_mem", rdata, 32'h55ADBEEF);
    tick();

    // Violation in the same cycle as clear is captured
    step(0, 1, 32'h12, 32'h0, 4'hF, 1); tick();
    chk_err("setclr", 1'b1, 2'd2, 32'h12);
    chk("setclr_wrcnt", wr_count, 32'd5);
    step(0, 0, 32'h0, 32'h0, 4'h0, 1); tick();
    chk_err("clr2", 1'b0, 2'd0, 32'h0);

    // Reset mid-stream: async clear, write during reset dropped
    step(0, 1, 32'h8, 32'hA5A5A5A5, 4'hF, 0); tick();
    step(1, 0, 32'h9, 32'h0, 4'hF, 0); tick();
    chk_err("pre_rst", 1'b1, 2'd2, 32'h9);
    step(1, 0, 32'h8, 32'h0, 4'hF, 0);
    chk("pre_rst_rdata", rdata, 32'hA5A5A5A5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_rdcnt", rd_count, 32'h0);
    chk("mid_rst_wrcnt", wr_count, 32'h0);
    chk_err("mid_rst", 1'b0, 2'd0, 32'h0);
    ren = 1'b0; wen = 1'b1; wdata = 32'h0;
    tick();
    @(negedge clk);
    rst = 1'b0; wen = 1'b0; ren = 1'b1; addr = 32'h8; mask = 4'hF;
    #1;
    chk("post_rst_rdata", rdata, 32'hA5A5A5A5);
    tick();
    chk("post_rst_rdcnt", rd_count, 32'd1);
    chk("post_rst_wrcnt", wr_count, 32'd0);

    // Write counter saturation
    @(negedge clk);
    ren = 1'b0;
    force dut.r_wr_count = 32'hFFFFFFFE;
    #1 release dut.r_wr_count;
    wen = 1'b1; addr = 32'h100; wdata = 32'h1; mask = 4'hF;
    tick();
    chk("sat1", wr_count, 32'hFFFFFFFF);
    step(0, 1, 32'h104, 32'h2, 4'hF, 0); tick();
    chk("sat2", wr_count, 32'hFFFFFFFF);
    step(0, 1, 32'h108, 32'h3, 4'hF, 0); tick();
    chk("sat3", wr_count, 32'hFFFFFFFF);
    step(1, 0, 32'h104, 32'h0, 4'hF, 0);
    chk("sat_mem", rdata, 32'h2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (memory side) of the hart's data-memory port: accepts word-aligned address, ren/wen and 4-bit byte mask each cycle.
- Reads return combinationally; masked writes commit on the next rising edge.
- Adds sticky protocol-violation capture and saturating access counters.
- Used as the dmem model in phase-3 single-cycle benches and reused behind later memory wrappers.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words backed; power of two, min 4.
- BASE_ADDR, 32'h00000000: byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- i_clk  input  1  global clock
- i_rst  input  1  asynchronous active-high reset
- i_dmem_addr  input  32  byte address, expected word aligned
- i_dmem_ren  input  1  read enable
- i_dmem_wen  input  1  write enable
- i_dmem_wdata  input  32  write data, lane-positioned
- i_dmem_mask  input  4  byte-lane enables, bit n = bits [8n+7:8n]
- o_dmem_rdata  output  32  read data, combinational
- i_err_clr  input  1  synchronous clear of sticky error state
- o_err  output  1  sticky: a violation has occurred
- o_err_cause  output  2  cause of first captured violation
- o_err_addr  output  32  i_dmem_addr of first captured violation
- o_rd_count  output  32  accepted reads, saturating
- o_wr_count  output  32  accepted writes, saturating

Behaviour:
- Reset (async assert, released on clock domain): o_err=0, o_err_cause=0, o_err_addr=0, o_rd_count=0, o_wr_count=0. While i_rst high, o_dmem_rdata=0 and writes are ignored. Array contents are NOT reset; they hold across reset.
- Index = (addr - BASE_ADDR) >> 2. In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. Compute with 33-bit arithmetic so the upper bound near 32'hFFFFFFFF does not wrap.
- Violation checks apply only when ren|wen. Priority order:
  - cause 2'd1: ren & wen both high.
  - cause 2'd2: addr[1:0] != 0.
  - cause 2'd3: out of range.
  - 2'd0 = none.
- Violating access: no array write, o_dmem_rdata=0, counters unchanged.
- Legal read (ren & !wen): o_dmem_rdata lane n = mem[idx] lane n if mask[n], else 8'h00. Zero latency; rdata is 0 whenever ren is low.
- Legal write (wen & !ren): on the next posedge, lanes with mask[n]=1 take wdata lanes; other lanes are unchanged. A read of the same word in the following cycle returns the new data. There is no write-to-read bypass within a cycle (reading and writing together is illegal anyway).
- mask=4'b0000 with ren or wen: legal no-op access. It is counted, no lanes are touched, and rdata=0.
- Counters: +1 per legal accepted access per cycle. Each holds at 32'hFFFFFFFF with no wrap.
- Error capture:
  - On the first violation while o_err=0, register o_err=1, the cause and the addr at the posedge.
  - Later violations do not overwrite the captured values.
  - i_err_clr clears all three at the posedge. If a violation occurs in the same cycle as i_err_clr, the new violation is captured (set wins over clear).
- Reset mid-operation: an in-flight write on the asserting edge is dropped; the array keeps its prior value.

Decomposition:
- Package dmem_pkg:
  - err_cause_t encodings: NONE=0, RW_BOTH=1, MISALIGN=2, RANGE=3.
  - Lane width constant 8 and lane count 4.
  - Helper function lane_merge(old, wdata, mask).
- Sub-module dmem_byte_bank: DEPTH_WORDS x 8 storage with one write-enable and a combinational read. Instantiate 4 times, one per lane; the top level holds decode, error and counter logic.

Test Plan:
- Full-word write/read: wen, addr=0x10, mask=4'hF, wdata=0xDEADBEEF; next cycle ren, mask=4'hF -> rdata=0xDEADBEEF, wr_count=1, rd_count=1.
- Byte write: after the above, wen, addr=0x10, mask=4'b1000, wdata=0x55000000; then ren, mask=4'hF -> 0x55ADBEEF. Read with mask=4'b1100 -> 0x55AD0000.
- Illegal ren&wen at addr=0x20, wdata=0x1 -> o_err=1, cause=1, err_addr=0x20; mem[0x20] unchanged. Following misaligned read at 0x23 -> cause still 1.
- Out of range with DEPTH_WORDS=1024: ren at 0x1000 -> cause=3, rdata=0. Read at 0xFFC is legal. After i_err_clr -> o_err=0. A violation in the same cycle as the clear is captured.
- Reset mid-stream: write 0xA5A5A5A5 to 0x8, then assert i_rst asynchronously between edges -> counters and err go 0 immediately, rdata=0. After release, read 0x8 -> 0xA5A5A5A5.
- Saturation: force o_wr_count to 0xFFFFFFFE, do 3 legal writes -> count 0xFFFFFFFF, stays.
